tuning_sequencer: RTL

TUNING_SEQUENCER -- requirements
Module: tuning_sequencer

---
 rtl/tuning_pkg.sv | 12 +
 rtl/seq_timer.sv | 16 +
 rtl/tuning_sequencer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/tuning_pkg.sv
// tuning_pkg: shared FSM state type, default tuning constants and timer width helper.
package tuning_pkg;
  typedef enum logic [2:0] {
    IDLE, SETTLE, MEASURE, WAIT_READY, UPDATE, CHECK, DONE, FAIL
  } state_t;
  localparam int DEF_MAX_ITER = 12;
  localparam int DEF_SETTLE_CYCLES = 3;
  localparam int DEF_TIMEOUT_CYCLES = 255;
  function automatic int cnt_w(int v);
    return v < 2 ? 1 : $clog2(v + 1);
  endfunction
endpackage

// File: rtl/seq_timer.sv
// seq_timer: loadable down-counter that holds at zero and flags it.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= load ? load_val : (cnt != '0 ? cnt - 1'b1 : cnt);
  assign zero = cnt == '0;
endmodule

// File: rtl/tuning_sequencer.sv
// tuning_sequencer: settle/measure/update loop driving Q measurement and bisection blocks.
// Define SEQ_TIMEOUT_EN to fail the run when meas_ready does not arrive within TIMEOUT_CYCLES.
module tuning_sequencer
  import tuning_pkg::*;
#(
  parameter int BUS_WIDTH = 10,
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 abort,
  input  logic                 meas_ready,
  input  logic                 setup_completed,
  output logic                 meas_start,
  output logic                 ctrl_enable,
  output logic                 busy,
  output logic                 done,
  output logic                 fail,
  output logic                 timeout,
  output logic [BUS_WIDTH-1:0] iter_count
);
  localparam int SET_LD = SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1;
  localparam state_t FIRST = SETTLE_CYCLES == 0 ? MEASURE : SETTLE;
  localparam logic FIRST_MS = SETTLE_CYCLES == 0;
`ifdef SEQ_TIMEOUT_EN
  localparam int TW = cnt_w(SETTLE_CYCLES > TIMEOUT_CYCLES ? SETTLE_CYCLES : TIMEOUT_CYCLES);
  localparam int TMO_LD = TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1;
`else
  localparam int TW = cnt_w(SETTLE_CYCLES);
`endif
  state_t state;
  logic tmr_load, tmr_zero;
  logic [TW-1:0] tmr_val;
  // The timer is preloaded in every state that precedes a timed state, so no next-state decode is needed.
`ifdef SEQ_TIMEOUT_EN
  assign tmr_load = !(state inside {SETTLE, WAIT_READY});
  assign tmr_val = state == MEASURE ? TW'(TMO_LD) : TW'(SET_LD);
`else
  logic unused_cfg;
  assign unused_cfg = |TIMEOUT_CYCLES;
  assign tmr_load = state != SETTLE;
  assign tmr_val = TW'(SET_LD);
  assign timeout = 1'b0;
`endif
  assign busy = !(state inside {IDLE, DONE, FAIL});
  seq_timer #(.W(TW)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(tmr_load),
    .load_val(tmr_val),
    .zero(tmr_zero)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      meas_start <= 1'b0;
      ctrl_enable <= 1'b0;
      done <= 1'b0;
      fail <= 1'b0;
      iter_count <= '0;
`ifdef SEQ_TIMEOUT_EN
      timeout <= 1'b0;
`endif
    end else begin
      meas_start <= 1'b0;
      ctrl_enable <= 1'b0;
      case (state)
        IDLE, DONE, FAIL:
          if (go) begin
            state <= FIRST;
            meas_start <= FIRST_MS;
            iter_count <= '0;
            done <= 1'b0;
            fail <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            timeout <= 1'b0;
`endif
          end
        SETTLE:
          if (abort) state <= IDLE;
          else if (tmr_zero) begin
            state <= MEASURE;
            meas_start <= 1'b1;
          end
        MEASURE: state <= abort ? IDLE : WAIT_READY;
        WAIT_READY:
          if (abort) state <= IDLE;
          else if (meas_ready) begin
            state <= UPDATE;
            ctrl_enable <= 1'b1;
            iter_count <= &iter_count ? iter_count : iter_count + 1'b1;
          end
`ifdef SEQ_TIMEOUT_EN
          else if (tmr_zero) begin
            state <= FAIL;
            fail <= 1'b1;
            timeout <= 1'b1;
          end
`endif
        UPDATE: state <= abort ? IDLE : CHECK;
        CHECK:
          if (abort) state <= IDLE;
          else if (setup_completed) begin
            state <= DONE;
            done <= 1'b1;
          end else if (iter_count == BUS_WIDTH'(MAX_ITER)) begin
            state <= FAIL;
            fail <= 1'b1;
          end else begin
            state <= FIRST;
            meas_start <= FIRST_MS;
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
